// File: rtl/axil_fram_slave_pkg.sv
// Shared types and constants for the AXI4-Lite FRAM emulator.
// Register offsets are byte offsets inside the 16-byte window.
package axil_fram_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    localparam logic [3:0] REG_DEV    = 4'h0;
    localparam logic [3:0] REG_ADDR   = 4'h4;
    localparam logic [3:0] REG_DATA   = 4'h8;
    localparam logic [3:0] REG_STATUS = 4'hC;

    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

    localparam logic [3:0] DEV_TYPE = 4'b1010;

    // Strips the byte-lane bits so the two register-select bits can be compared to an offset.
    function automatic logic [3:0] regSelect(input logic [3:0] byteAddr);
        return byteAddr & 4'b1100;
    endfunction

endpackage

// File: rtl/axil_fram_slave_if.sv
// AXI4-Lite bus bundle between a master and the FRAM emulator.
interface axil_fram_slave_if;
    logic [3:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_fram_slave_fram_byte_bank.sv
// One byte lane of the emulated FRAM array: single write port, registered read port.
module fram_byte_bank #(
    parameter int DEPTH = 512,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [IW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic          re_i,
    input  logic [IW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_q;

    // Like the real device, the array keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axil_fram_slave.sv
// AXI4-Lite responder emulating an FM24CLxx FRAM behind DEV/ADDR/DATA/STATUS registers.
// DATA accesses auto-increment the word pointer and are rejected when DEV does not match the pins.
module axil_fram_slave
    import axil_fram_pkg::*;
#(
    parameter int         FM24CLXX_TYPE = 2048,
    parameter logic [2:0] FM24CLXX_ADDR = 3'b000
) (
    input logic               clk,
    input logic               rst,
    axil_fram_slave_if.slave  s_axil
);

    localparam int AW = $clog2(FM24CLXX_TYPE);
    localparam int IW = AW - 2;

    wstate_t     wState_q;
    logic        awHeld_q, wHeld_q;
    logic [3:0]  awAddr_q;
    logic [31:0] wData_q;
    logic [3:0]  wStrb_q;
    logic        awready_q, wready_q, bvalid_q;
    resp_t       bresp_q;

    rstate_t     rState_q;
    logic [3:0]  arAddr_q;
    logic        arready_q, rvalid_q, rIsData_q;
    resp_t       rresp_q;
    logic [31:0] rdata_q;

    logic [7:0]    dev_q, dev_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   count_q, count_d;
    logic          err_q, err_d;

    logic          awFire, wFire, arFire, wGoCommit, devMatch;
    logic          wCommit, rFetch, wDataAcc, rDataAcc;
    logic [3:0]    wSel, rSel;
    logic [IW-1:0] bankIdx;
    logic [7:0]    bankRdata [4];

    assign awFire    = s_axil.awvalid && awready_q;
    assign wFire     = s_axil.wvalid && wready_q;
    assign arFire    = s_axil.arvalid && arready_q;
    assign wGoCommit = (wState_q == W_IDLE) && (awHeld_q || awFire) && (wHeld_q || wFire);
    assign devMatch  = (dev_q[7:1] == {DEV_TYPE, FM24CLXX_ADDR});
    assign wCommit   = (wState_q == W_COMMIT);
    assign rFetch    = (rState_q == R_FETCH);
    assign wSel      = regSelect(awAddr_q);
    assign rSel      = regSelect(arAddr_q);
    assign wDataAcc  = wCommit && (wSel == REG_DATA);
    assign rDataAcc  = rFetch && (rSel == REG_DATA);
    assign bankIdx   = addr_q[AW-1:2];

    // Write channel: AW and W are parked independently, then committed together for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wState_q  <= W_IDLE;
            awHeld_q  <= 1'b0;
            wHeld_q   <= 1'b0;
            awAddr_q  <= '0;
            wData_q   <= '0;
            wStrb_q   <= '0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
        end else begin
            case (wState_q)
                W_IDLE: begin
                    if (awFire) begin
                        awHeld_q <= 1'b1;
                        awAddr_q <= s_axil.awaddr;
                    end
                    if (wFire) begin
                        wHeld_q <= 1'b1;
                        wData_q <= s_axil.wdata;
                        wStrb_q <= s_axil.wstrb;
                    end
                    if (wGoCommit) begin
                        wState_q  <= W_COMMIT;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                    end else begin
                        awready_q <= !(awHeld_q || awFire);
                        wready_q  <= !(wHeld_q || wFire);
                    end
                end
                W_COMMIT: begin
                    wState_q <= W_RESP;
                    awHeld_q <= 1'b0;
                    wHeld_q  <= 1'b0;
                    bvalid_q <= 1'b1;
                    bresp_q  <= (wDataAcc && !devMatch) ? SLVERR : OKAY;
                end
                W_RESP: begin
                    if (s_axil.bready) begin
                        wState_q  <= W_IDLE;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                default: wState_q <= W_IDLE;
            endcase
        end
    end

    // Read channel: AR is refused while a write commits so a following read observes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rState_q  <= R_IDLE;
            arAddr_q  <= '0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
            rIsData_q <= 1'b0;
        end else begin
            case (rState_q)
                R_IDLE: begin
                    if (arFire) begin
                        rState_q  <= R_FETCH;
                        arAddr_q  <= s_axil.araddr;
                        arready_q <= 1'b0;
                    end else begin
                        arready_q <= !wGoCommit;
                    end
                end
                R_FETCH: begin
                    rState_q  <= R_DATA;
                    rvalid_q  <= 1'b1;
                    rIsData_q <= (rSel == REG_DATA) && devMatch;
                    rresp_q   <= ((rSel == REG_DATA) && !devMatch) ? SLVERR : OKAY;
                    case (rSel)
                        REG_DEV:    rdata_q <= {24'd0, dev_q};
                        REG_ADDR:   rdata_q <= 32'(addr_q);
                        REG_STATUS: rdata_q <= {15'd0, err_q, count_q};
                        default:    rdata_q <= '0;
                    endcase
                end
                R_DATA: begin
                    if (s_axil.rready) begin
                        rState_q  <= R_IDLE;
                        rvalid_q  <= 1'b0;
                        arready_q <= !wGoCommit;
                    end
                end
                default: rState_q <= R_IDLE;
            endcase
        end
    end

    // A write commit and a read fetch can overlap, so both pointer/counter bumps are summed here.
    always_comb begin
        dev_d   = dev_q;
        addr_d  = addr_q;
        count_d = count_q;
        err_d   = err_q;
        if (wCommit && (wSel == REG_DEV) && wStrb_q[0]) begin
            dev_d = wData_q[7:0];
        end
        if (wCommit && (wSel == REG_ADDR)) begin
            for (int b = 2; b < AW; b++) begin
                if (wStrb_q[b/8]) begin
                    addr_d[b] = wData_q[b];
                end
            end
        end else begin
            if (wDataAcc && devMatch) begin
                addr_d = addr_d + AW'(4);
            end
            if (rDataAcc && devMatch) begin
                addr_d = addr_d + AW'(4);
            end
        end
        if (wCommit && (wSel == REG_STATUS)) begin
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            if (wDataAcc && devMatch) begin
                count_d = count_d + 16'd1;
            end
            if (rDataAcc && devMatch) begin
                count_d = count_d + 16'd1;
            end
            if ((wDataAcc || rDataAcc) && !devMatch) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dev_q   <= {DEV_TYPE, FM24CLXX_ADDR, 1'b0};
            addr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            dev_q   <= dev_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : gBank
        fram_byte_bank #(
            .DEPTH(FM24CLXX_TYPE / 4),
            .IW   (IW)
        ) uBank (
            .clk    (clk),
            .we_i   (wDataAcc && devMatch && wStrb_q[i]),
            .waddr_i(bankIdx),
            .wdata_i(wData_q[8*i +: 8]),
            .re_i   (rDataAcc && devMatch),
            .raddr_i(bankIdx),
            .rdata_o(bankRdata[i])
        );
    end

    assign s_axil.awready = awready_q;
    assign s_axil.wready  = wready_q;
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.bresp   = bresp_q;
    assign s_axil.arready = arready_q;
    assign s_axil.rvalid  = rvalid_q;
    assign s_axil.rresp   = rresp_q;
    assign s_axil.rdata   = rIsData_q ? {bankRdata[3], bankRdata[2], bankRdata[1], bankRdata[0]} : rdata_q;

endmodule
